// File: rtl/gpio_vector_pkg.sv
// gpio_vector_pkg: pad map constants and the fixed output-enable mask for openframe_gpio_vector
package gpio_vector_pkg;
    localparam int NUM_GPIO    = 44;
    localparam int VEC_LSB     = 16;
    localparam int UART_TX_PAD = 6;
    localparam int HK_CSB_PAD  = 3;
    localparam int CLK_PAD     = 38;
    localparam int NUM_FLASH   = 6;
    localparam int FLASH_PADS [NUM_FLASH] = '{36, 37, 39, 40, 41, 42};

    // Output enables are active-low; only the vector pads and the TX pad drive.
    // Reserved pads are forced released last so a wide vector can never claim them.
    function automatic logic [NUM_GPIO-1:0] oeb_mask(int width);
        logic [NUM_GPIO-1:0] m;
        m = '1;
        for (int i = 0; i < width; i++) m[VEC_LSB + i] = 1'b0;
        m[UART_TX_PAD] = 1'b0;
        m[HK_CSB_PAD]  = 1'b1;
        m[CLK_PAD]     = 1'b1;
        for (int i = 0; i < NUM_FLASH; i++) m[FLASH_PADS[i]] = 1'b1;
        return m;
    endfunction
endpackage

// File: rtl/gpio_vector_uart_tx.sv
// gpio_vector_uart_tx: 8N1-style shift-register transmitter (start 0, data LSB first, stop 1)
//   clock, rst_n : clock and async active-low reset (line returns to 1)
//   start, data  : load a frame; ignored while busy
//   tx, busy     : serial line and frame-in-progress flag
module gpio_vector_uart_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] data,
    output logic              tx,
    output logic              busy
);
    localparam int FW = DATA_W + 2;
    localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = $clog2(FW + 1);

    logic [FW-1:0] sh;
    logic [CW-1:0] cnt;
    logic [BW-1:0] left;

    assign busy = left != '0;
    assign tx   = sh[0];

    // Ones shift in from the top, so the line rests at 1 once the frame is out.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            sh   <= '1;
            cnt  <= '0;
            left <= '0;
        end else if (start && !busy) begin
            sh   <= {1'b1, data, 1'b0};
            cnt  <= '0;
            left <= BW'(FW);
        end else if (busy) begin
            if (cnt == CW'(CLKS_PER_BIT - 1)) begin
                cnt  <= '0;
                sh   <= {1'b1, sh[FW-1:1]};
                left <= left - 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/openframe_gpio_vector.sv
// openframe_gpio_vector: free-running counting vector on gpio[23:16] for pad/clock bring-up
//   clock    : system clock (from gpio[38])
//   resetb   : async active-low reset, release synchronized over 2 flops
//   gpio_in  : pad inputs (not used by the logic)
//   gpio_out : vector on pads 16+, UART TX (or constant 1) on pad 6, 0 elsewhere
//   gpio_oeb : constant active-low enable mask
// Optional GPIO_VECTOR_UART_EN: each new vector value is sent as a serial frame on gpio[6].
module openframe_gpio_vector
    import gpio_vector_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int PRESCALE     = 256,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                clock,
    input  logic                resetb,
    input  logic [NUM_GPIO-1:0] gpio_in,
    output logic [NUM_GPIO-1:0] gpio_out,
    output logic [NUM_GPIO-1:0] gpio_oeb
);
    localparam int PW = $clog2(PRESCALE);

    logic [1:0]       sync;
    logic             rst_n;
    logic [PW-1:0]    pre;
    logic             step;
    logic [WIDTH-1:0] vec;
    logic [WIDTH-1:0] vec_next;
    logic             tx;
    logic             in_unused;

    assign in_unused = ^gpio_in;

    // Assertion is immediate through the flops' async clear; only release is synchronized.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) sync <= '0;
        else         sync <= {sync[0], 1'b1};
    end

    assign rst_n    = sync[1];
    assign step     = pre == PW'(PRESCALE - 1);
    assign vec_next = vec + 1'b1;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            pre <= '0;
            vec <= '0;
        end else begin
            pre <= step ? '0 : pre + 1'b1;
            if (step) vec <= vec_next;
        end
    end

`ifdef GPIO_VECTOR_UART_EN
    logic tx_busy;

    // Loading on the same edge as the vector update makes the start bit coincide with the new value.
    gpio_vector_uart_tx #(
        .DATA_W      (WIDTH),
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clock(clock),
        .rst_n(rst_n),
        .start(step && !tx_busy),
        .data (vec_next),
        .tx   (tx),
        .busy (tx_busy)
    );
`else
    localparam int cpb_unused = CLKS_PER_BIT;

    assign tx = 1'b1;
`endif

    always_comb begin
        gpio_out = '0;
        gpio_out[VEC_LSB +: WIDTH] = vec;
        gpio_out[UART_TX_PAD] = tx;
    end

    assign gpio_oeb = oeb_mask(WIDTH);
endmodule

// File: tb/tb_openframe_gpio_vector.sv
// tb_openframe_gpio_vector: random-stimulus check of the counting vector against an edge-count model
module tb_openframe_gpio_vector;
    localparam int P_A = 256;
    localparam int P_B = 2;
    localparam logic [43:0] OEB = 44'hFFFFF00FFBF;
`ifdef GPIO_VECTOR_UART_EN
    localparam logic [43:0] OMASK = ~(44'h1 << 6);
`else
    localparam logic [43:0] OMASK = '1;
`endif

    logic        clock = 1'b0;
    logic        resetb = 1'b0;
    logic [43:0] pads = '0;
    logic [43:0] gpio_in;
    logic [43:0] out_a, oeb_a, out_b, oeb_b;
    int          since = 0;
    int          total = 0;
    int          bad = 0;

    always #5 clock = ~clock;

    assign gpio_in = {pads[43:39], clock, pads[37:0]};

    openframe_gpio_vector dut_a (
        .clock(clock), .resetb(resetb), .gpio_in(gpio_in), .gpio_out(out_a), .gpio_oeb(oeb_a)
    );

    openframe_gpio_vector #(.PRESCALE(P_B)) dut_b (
        .clock(clock), .resetb(resetb), .gpio_in(gpio_in), .gpio_out(out_b), .gpio_oeb(oeb_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, since);
        end
    endtask

    // Rising edges seen with resetb high since the last reset.
    always @(posedge clock) since = resetb ? since + 1 : 0;

    // Value N is due 2 + N*p edges after release; 8-bit truncation gives the wrap.
    function automatic logic [7:0] model(int p);
        if (!resetb || since < 2) return '0;
        return 8'((since - 2) / p);
    endfunction

    function automatic logic [43:0] pads_exp(logic [7:0] v);
        logic [43:0] e;
        e = '0;
        e[23:16] = v;
        e[6] = 1'b1;
        return e;
    endfunction

    always @(negedge clock) begin
        check("out_a", out_a & OMASK, pads_exp(model(P_A)) & OMASK);
        check("oeb_a", oeb_a, OEB);
        check("out_b", out_b & OMASK, pads_exp(model(P_B)) & OMASK);
        check("oeb_b", oeb_b, OEB);
        if (resetb && since == 258)  check("vec_1_at_258", out_a[23:16], 8'd1);
        if (resetb && since == 514)  check("vec_2_at_514", out_a[23:16], 8'd2);
        if (resetb && since == 8450) check("vec_33_at_8450", out_a[23:16], 8'd33);
        if (resetb && since == 2 + 255 * P_B) check("b_ff", out_b[23:16], 8'hFF);
        if (resetb && since == 2 + 256 * P_B) check("b_wrap_00", out_b[23:16], 8'h00);
    end

`ifdef GPIO_VECTOR_UART_EN
    localparam int CPB = 16;
    int          ub_cnt = -1;
    logic [7:0]  ub_byte = '0;
    logic [7:0]  ub_exp = '0;
    logic [7:0]  ub_last = '0;

    always @(negedge clock) begin
        if (!resetb) begin
            ub_cnt  = -1;
            ub_last = '0;
        end else if (ub_cnt < 0) begin
            if (!out_a[6]) begin
                ub_cnt = 0;
                ub_exp = out_a[23:16];
                check("uart_start_lag", 64'((since - 2) % P_A), 64'd0);
            end
        end else begin
            ub_cnt++;
            if (ub_cnt > CPB && ub_cnt < 9 * CPB && ub_cnt % CPB == CPB / 2)
                ub_byte = {out_a[6], ub_byte[7:1]};
            if (ub_cnt == 9 * CPB + CPB / 2) begin
                check("uart_stop", out_a[6], 1'b1);
                check("uart_byte", ub_byte, ub_exp);
                check("uart_seq", ub_byte, ub_last + 8'd1);
                ub_last = ub_byte;
                ub_cnt  = -1;
            end
        end
    end
`endif

    task automatic pulse_reset(input int hold);
        #1 resetb = 1'b0;
        #1;
        check("async_rst_a", out_a[23:16], 8'h00);
        check("async_rst_b", out_b[23:16], 8'h00);
        check("async_rst_tx", out_a[6], 1'b1);
        repeat (hold) @(negedge clock);
        resetb = 1'b1;
    endtask

    initial begin
        repeat (80) begin
            @(negedge clock);
            pads = {$urandom, $urandom};
        end
        check("rst_vec", out_a[23:16], 8'h00);
        check("rst_tx", out_a[6], 1'b1);
        check("rst_oeb", oeb_a, OEB);
        resetb = 1'b1;
        for (int i = 0; i < 6000 && since != 2 + 18 * P_A; i++) begin
            @(negedge clock);
            pads = {$urandom, $urandom};
        end
        check("reach_0x12", out_a[23:16], 8'h12);
        pulse_reset($urandom_range(1, 20));
        repeat (8460) begin
            @(negedge clock);
            pads = {$urandom, $urandom};
            pads[3] = 1'b1;
        end
        check("iso_oeb", {oeb_a[42:36], oeb_a[3]}, 8'hFF);
        check("iso_out", {out_a[42:36], out_a[3]}, 8'h00);
        repeat ($urandom_range(100, 3000)) @(negedge clock);
        pulse_reset($urandom_range(1, 10));
        repeat (600) begin
            @(negedge clock);
            pads = {$urandom, $urandom};
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
